// File: rtl/icache_sa_ro.sv
// Read-only set-associative instruction cache (1 or 2 ways, per-set LRU, 128-bit lines).
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module icache_sa_ro #(
    parameter int ADDR_W   = 30,
    parameter int SET_BITS = 3,
    parameter int WAYS     = 2
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_flush,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int TAG_W = ADDR_W - 2 - SET_BITS;
    localparam int SETS  = 1 << SET_BITS;

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("icache_sa_ro: WAYS must be 1 or 2");
    end
    if (SET_BITS < 1 || SET_BITS > 6) begin : g_bad_sets
        $error("icache_sa_ro: SET_BITS must be 1..6");
    end

    typedef enum logic {LOOKUP, ALLOCATE} state_t;
    state_t state, state_d;

    logic [SETS-1:0][WAYS-1:0]  valid;
    logic [SETS-1:0]            lru;    // way to evict next when both ways are valid
    logic [WAYS-1:0][TAG_W-1:0] tag_arr  [SETS];
    logic [WAYS-1:0][127:0]     data_arr [SETS];

    logic [1:0]          off;
    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic [WAYS-1:0]     way_hit;
    logic                hit, hit_way, victim, fill, lru_touch;

    assign off      = proc_addr[1:0];
    assign idx      = proc_addr[SET_BITS+1:2];
    assign tag      = proc_addr[ADDR_W-1:SET_BITS+2];
    assign mem_addr = proc_addr[ADDR_W-1:2];

    always_comb begin
        hit_way = 1'b0;
        victim  = lru[idx];
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = valid[idx][w] && (tag_arr[idx][w] == tag);
            if (way_hit[w]) hit_way = 1'(w);
        end
        // Lowest-numbered invalid way wins over LRU.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[idx][w]) victim = 1'(w);
        end
        hit = |way_hit;
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) state <= LOOKUP;
        else            state <= state_d;
    end

    // Outputs are gated by reset so an async reset drops stall/read immediately.
    always_comb begin
        state_d    = state;
        proc_stall = 1'b0;
        proc_rdata = 32'h0;
        mem_read   = 1'b0;
        fill       = 1'b0;
        lru_touch  = 1'b0;
        if (!proc_reset) begin
            case (state)
                LOOKUP: begin
                    if (!hit) begin
                        proc_stall = 1'b1;
                        state_d    = ALLOCATE;
                    end else if (proc_flush) begin
                        proc_stall = 1'b1;
                    end else begin
                        proc_rdata = data_arr[idx][hit_way][{off, 5'b0} +: 32];
                        lru_touch  = 1'b1;
                    end
                end
                ALLOCATE: begin
                    proc_stall = 1'b1;
                    if (mem_ready) begin
                        fill    = !proc_flush;
                        state_d = LOOKUP;
                    end else begin
                        mem_read = 1'b1;
                    end
                end
                default: state_d = LOOKUP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            valid <= '0;
            lru   <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag_arr[s]  <= '0;
                data_arr[s] <= '0;
            end
        end else begin
            if (fill) begin
                valid[idx][victim]    <= 1'b1;
                tag_arr[idx][victim]  <= tag;
                data_arr[idx][victim] <= mem_rdata;
                lru[idx]              <= (WAYS == 2) ? ~victim : 1'b0;
            end
            if (lru_touch)
                lru[idx] <= (WAYS == 2) ? ~hit_way : 1'b0;
            if (proc_flush) begin
                valid <= '0;
                lru   <= '0;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (lru_touch)                                 hit_cnt  <= hit_cnt + 32'd1;
            if (state == LOOKUP && state_d == ALLOCATE)    miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule
